// File: rtl/FPU_pkg.sv
// Shared FPU definitions: opcodes, format codes, canonical NaN and the
// sign-injection sign rule used by the sign injector.
package FPU_pkg;

    typedef enum logic [4:0] {
        FPU_OP_ADD    = 5'd0,
        FPU_OP_SUB    = 5'd1,
        FPU_OP_MUL    = 5'd2,
        FPU_OP_DIV    = 5'd3,
        FPU_OP_SQRT   = 5'd4,
        FPU_OP_FMADD  = 5'd5,
        FPU_OP_MIN    = 5'd6,
        FPU_OP_MAX    = 5'd7,
        FPU_OP_CMP    = 5'd8,
        FPU_OP_CLASS  = 5'd9,
        FPU_OP_SGNJ   = 5'd10,
        FPU_OP_SGNJN  = 5'd11,
        FPU_OP_SGNJX  = 5'd12,
        FPU_OP_CVT    = 5'd13
    } fpu_op_e;

    localparam logic        FPU_FMT_S       = 1'b0;
    localparam logic        FPU_FMT_D       = 1'b1;
    localparam logic [31:0] CANONICAL_NAN_S = 32'h7FC0_0000;

    // True for the three opcodes this block claims.
    function automatic logic is_sgnj_op(input logic [4:0] op);
        return (op == FPU_OP_SGNJ) || (op == FPU_OP_SGNJN) || (op == FPU_OP_SGNJX);
    endfunction

    // Result sign for a sign-injection opcode given the two operand signs.
    function automatic logic sgnj_sign(input logic [4:0] op,
                                       input logic       sign_a,
                                       input logic       sign_b);
        case (op)
            FPU_OP_SGNJN: return !sign_b;
            FPU_OP_SGNJX: return sign_a ^ sign_b;
            default:      return sign_b;
        endcase
    endfunction

endpackage

// File: rtl/fpu_pipe_reg.sv
// One elastic pipeline register: holds a data word plus valid, loads when
// empty or when its current content leaves downstream in the same cycle.
module fpu_pipe_reg #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             up_valid,
    input  logic [WIDTH-1:0] up_data,
    output logic             up_ready,
    output logic             dn_valid,
    output logic [WIDTH-1:0] dn_data,
    input  logic             dn_ready
);

    assign up_ready = !dn_valid || dn_ready;

    // Register update: reset and flush clear everything, otherwise load the
    // upstream word (or an empty, zeroed slot) whenever this stage can move.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            dn_valid <= 1'b0;
            dn_data  <= '0;
        end else if (up_ready) begin
            dn_valid <= up_valid;
            dn_data  <= up_valid ? up_data : '0;
        end
    end

endmodule

// File: rtl/sign_injector.sv
// FSGNJ/FSGNJN/FSGNJX unit: combinational sign injection in front of a
// chain of STAGES elastic registers carrying result and valid.
module sign_injector
    import FPU_pkg::*;
#(
    parameter int FLEN   = 32,
    parameter int STAGES = 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            flush,
    input  logic            valid_in,
    output logic            ready_out,
    output logic            valid_out,
    input  logic            ready_in,
    input  logic [4:0]      op,
    input  logic            fmt,
    input  logic [FLEN-1:0] a,
    input  logic [FLEN-1:0] b,
    output logic [FLEN-1:0] float_out
);

    logic [FLEN-1:0] result;

    logic            stage_valid [STAGES+1];
    logic            stage_ready [STAGES+1];
    logic [FLEN-1:0] stage_data  [STAGES+1];

    generate
        if (FLEN == 64) begin : g_flen64
            logic [31:0] a_single;
            logic        b_sign_s;
            logic        unused_bits;

            assign unused_bits = ^b[30:0];

            // Single values must be NaN-boxed; unboxed operands become the
            // canonical NaN and the single result is boxed on the way out.
            always_comb begin
                a_single = (&a[63:32]) ? a[31:0] : CANONICAL_NAN_S;
                b_sign_s = (&b[63:32]) ? b[31] : CANONICAL_NAN_S[31];
                if (fmt == FPU_FMT_D) begin
                    result = {sgnj_sign(op, a[63], b[63]), a[62:0]};
                end else begin
                    result = {32'hFFFF_FFFF, sgnj_sign(op, a_single[31], b_sign_s),
                              a_single[30:0]};
                end
            end
        end else begin : g_flen32
            logic unused_bits;

            assign unused_bits = ^{fmt, b[30:0]};

            // Single precision only: replace the sign bit, keep the rest of a.
            always_comb begin
                result = {sgnj_sign(op, a[31], b[31]), a[30:0]};
            end
        end
    endgenerate

    assign stage_valid[0]      = valid_in && is_sgnj_op(op);
    assign stage_data[0]       = result;
    assign stage_ready[STAGES] = ready_in;
    assign ready_out           = stage_ready[0];
    assign valid_out           = stage_valid[STAGES];
    assign float_out           = stage_data[STAGES];

    generate
        for (genvar k = 0; k < STAGES; k++) begin : g_stage
            fpu_pipe_reg #(
                .WIDTH (FLEN)
            ) u_reg (
                .clk      (clk),
                .reset    (reset),
                .flush    (flush),
                .up_valid (stage_valid[k]),
                .up_data  (stage_data[k]),
                .up_ready (stage_ready[k]),
                .dn_valid (stage_valid[k+1]),
                .dn_data  (stage_data[k+1]),
                .dn_ready (stage_ready[k+1])
            );
        end
    endgenerate

endmodule

// File: tb/tb_sign_injector.sv
// Bench for sign_injector: three instances (32-bit/1 stage, 64-bit/3 stages,
// 64-bit/2 stages) share one stimulus stream; each has its own scoreboard.
module tb_sign_injector;
    import FPU_pkg::*;

    logic        clk = 1'b0;
    logic        reset, flush, valid_in, ready_in, fmt;
    logic [4:0]  op;
    logic [63:0] a, b;

    logic        rdy_s1, vld_s1;
    logic [31:0] out_s1;
    logic        rdy_s3, vld_s3;
    logic [63:0] out_s3;
    logic        rdy_s2, vld_s2;
    logic [63:0] out_s2;

    int checks = 0;
    int errors = 0;
    int cycle  = 0;

    typedef struct {
        int          idx;
        logic [63:0] data;
        int          cyc;
    } sb_t;
    sb_t sb[$];

    int          stages_tbl [3] = '{1, 3, 2};
    int          flen_tbl   [3] = '{32, 64, 64};
    logic        hold_pend  [3] = '{1'b0, 1'b0, 1'b0};
    logic [63:0] hold_data  [3];

    always #5 clk = ~clk;

    sign_injector #(.FLEN(32), .STAGES(1)) u_s1 (
        .clk(clk), .reset(reset), .flush(flush), .valid_in(valid_in),
        .ready_out(rdy_s1), .valid_out(vld_s1), .ready_in(ready_in),
        .op(op), .fmt(fmt), .a(a[31:0]), .b(b[31:0]), .float_out(out_s1));

    sign_injector #(.FLEN(64), .STAGES(3)) u_s3 (
        .clk(clk), .reset(reset), .flush(flush), .valid_in(valid_in),
        .ready_out(rdy_s3), .valid_out(vld_s3), .ready_in(ready_in),
        .op(op), .fmt(fmt), .a(a), .b(b), .float_out(out_s3));

    sign_injector #(.FLEN(64), .STAGES(2)) u_s2 (
        .clk(clk), .reset(reset), .flush(flush), .valid_in(valid_in),
        .ready_out(rdy_s2), .valid_out(vld_s2), .ready_in(ready_in),
        .op(op), .fmt(fmt), .a(a), .b(b), .float_out(out_s2));

    // Reference result from the instruction definition: pick the sign from
    // the operation, keep a's magnitude, box singles on a 64-bit datapath.
    function automatic logic [63:0] ref_result(input int flen, input logic fmt_v,
                                               input logic [4:0] op_v,
                                               input logic [63:0] av,
                                               input logic [63:0] bv);
        logic [31:0] sa, sb_v;
        logic        sign;
        if (flen == 64 && fmt_v == FPU_FMT_D) begin
            if (op_v == FPU_OP_SGNJ)       sign = bv[63];
            else if (op_v == FPU_OP_SGNJN) sign = ~bv[63];
            else                           sign = av[63] ^ bv[63];
            return (av & 64'h7FFF_FFFF_FFFF_FFFF) | ({63'd0, sign} << 63);
        end
        sa   = av[31:0];
        sb_v = bv[31:0];
        if (flen == 64) begin
            if (av[63:32] != 32'hFFFF_FFFF) sa   = 32'h7FC0_0000;
            if (bv[63:32] != 32'hFFFF_FFFF) sb_v = 32'h7FC0_0000;
        end
        if (op_v == FPU_OP_SGNJ)       sign = sb_v[31];
        else if (op_v == FPU_OP_SGNJN) sign = ~sb_v[31];
        else                           sign = sa[31] ^ sb_v[31];
        sa = (sa & 32'h7FFF_FFFF) | ({31'd0, sign} << 31);
        return (flen == 64) ? {32'hFFFF_FFFF, sa} : {32'd0, sa};
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] obs,
                               input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [4:0] op_v,
                                 input logic fmt_v, input logic [63:0] av,
                                 input logic [63:0] bv, input logic rdy,
                                 input logic fl, input logic rst);
        valid_in = v;
        op       = op_v;
        fmt      = fmt_v;
        a        = av;
        b        = bv;
        ready_in = rdy;
        flush    = fl;
        reset    = rst;
        #1;
    endtask

    // Scoreboard update for the current input set, then advance one cycle.
    task automatic tick();
        logic        ov [3];
        logic        orr[3];
        logic [63:0] od [3];
        int          jf;
        bit          found;
        sb_t         e;
        ov[0] = vld_s1; orr[0] = rdy_s1; od[0] = {32'd0, out_s1};
        ov[1] = vld_s3; orr[1] = rdy_s3; od[1] = out_s3;
        ov[2] = vld_s2; orr[2] = rdy_s2; od[2] = out_s2;
        for (int i = 0; i < 3; i++) begin
            if (hold_pend[i]) begin
                checkOutput($sformatf("hold_valid%0d", i), {63'd0, ov[i]}, 64'd1);
                checkOutput($sformatf("hold_data%0d", i), od[i], hold_data[i]);
            end
            if (ov[i] && ready_in) begin
                found = 0;
                jf    = 0;
                for (int j = 0; j < sb.size(); j++) begin
                    if (!found && sb[j].idx == i) begin
                        found = 1;
                        jf    = j;
                    end
                end
                if (!found) begin
                    checkOutput($sformatf("spurious_valid%0d", i), {63'd0, ov[i]}, 64'd0);
                end else begin
                    checkOutput($sformatf("result%0d", i), od[i], sb[jf].data);
                    checkOutput($sformatf("latency%0d", i),
                                {63'd0, (cycle - sb[jf].cyc) >= stages_tbl[i]}, 64'd1);
                    sb.delete(jf);
                end
            end
            hold_pend[i] = ov[i] && !ready_in && !flush && !reset;
            hold_data[i] = od[i];
        end
        if (flush || reset) sb.delete();
        for (int i = 0; i < 3; i++) begin
            if (!flush && !reset && valid_in && orr[i] &&
                (op inside {FPU_OP_SGNJ, FPU_OP_SGNJN, FPU_OP_SGNJX})) begin
                e.idx  = i;
                e.cyc  = cycle;
                e.data = ref_result(flen_tbl[i], fmt, op,
                                    (flen_tbl[i] == 32) ? {32'd0, a[31:0]} : a,
                                    (flen_tbl[i] == 32) ? {32'd0, b[31:0]} : b);
                sb.push_back(e);
            end
        end
        @(posedge clk);
        @(negedge clk);
        cycle++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            applyStimulus(1'b0, FPU_OP_ADD, FPU_FMT_S, 64'd0, 64'd0, 1'b1, 1'b0, 1'b0);
            tick();
        end
    endtask

    initial begin
        logic [4:0]  ops_tbl [5];
        logic [63:0] ra, rb;
        int          left;
        ops_tbl = '{FPU_OP_SGNJ, FPU_OP_SGNJN, FPU_OP_SGNJX, FPU_OP_ADD, FPU_OP_MUL};

        // Reset state
        @(negedge clk);
        applyStimulus(1'b0, FPU_OP_ADD, FPU_FMT_S, 64'd0, 64'd0, 1'b1, 1'b0, 1'b1);
        tick();
        tick();
        checkOutput("reset_valid_s1", {63'd0, vld_s1}, 64'd0);
        checkOutput("reset_valid_s3", {63'd0, vld_s3}, 64'd0);
        checkOutput("reset_valid_s2", {63'd0, vld_s2}, 64'd0);
        checkOutput("reset_data_s1", {32'd0, out_s1}, 64'd0);
        checkOutput("reset_data_s3", out_s3, 64'd0);
        checkOutput("reset_data_s2", out_s2, 64'd0);
        checkOutput("reset_ready_s1", {63'd0, rdy_s1}, 64'd1);
        checkOutput("reset_ready_s3", {63'd0, rdy_s3}, 64'd1);
        checkOutput("reset_ready_s2", {63'd0, rdy_s2}, 64'd1);
        idle(2);

        // 32-bit SGNJN of 1.0 gives -1.0 one cycle after transfer
        applyStimulus(1'b1, FPU_OP_SGNJN, FPU_FMT_S, 64'h3F80_0000, 64'h3F80_0000,
                      1'b1, 1'b0, 1'b0);
        tick();
        checkOutput("sgnjn32_valid", {63'd0, vld_s1}, 64'd1);
        checkOutput("sgnjn32_data", {32'd0, out_s1}, 64'h0000_0000_BF80_0000);
        idle(5);

        // Unboxed single operand becomes canonical NaN, sign taken from b
        applyStimulus(1'b1, FPU_OP_SGNJ, FPU_FMT_S, 64'h0000_0000_3F80_0000,
                      64'hFFFF_FFFF_BF80_0000, 1'b1, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b0, FPU_OP_ADD, FPU_FMT_S, 64'd0, 64'd0, 1'b1, 1'b0, 1'b0);
        tick();
        checkOutput("nanbox_valid_s2", {63'd0, vld_s2}, 64'd1);
        checkOutput("nanbox_data_s2", out_s2, 64'hFFFF_FFFF_FFC0_0000);
        tick();
        checkOutput("nanbox_valid_s3", {63'd0, vld_s3}, 64'd1);
        checkOutput("nanbox_data_s3", out_s3, 64'hFFFF_FFFF_FFC0_0000);
        idle(5);

        // Double SGNJX: -2.0 xor negative zero sign gives +2.0
        applyStimulus(1'b1, FPU_OP_SGNJX, FPU_FMT_D, 64'hC000_0000_0000_0000,
                      64'h8000_0000_0000_0000, 1'b1, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b0, FPU_OP_ADD, FPU_FMT_S, 64'd0, 64'd0, 1'b1, 1'b0, 1'b0);
        tick();
        checkOutput("sgnjx_d_s2", out_s2, 64'h4000_0000_0000_0000);
        tick();
        checkOutput("sgnjx_d_s3", out_s3, 64'h4000_0000_0000_0000);
        idle(5);

        // Backpressure on the 3-stage instance: three buffered, fourth refused
        for (int k = 0; k < 4; k++) begin
            applyStimulus(1'b1, FPU_OP_SGNJ, FPU_FMT_S,
                          {32'hFFFF_FFFF, 32'h4000_0000 + k}, 64'hFFFF_FFFF_8000_0000,
                          1'b0, 1'b0, 1'b0);
            checkOutput($sformatf("bp_ready_%0d", k), {63'd0, rdy_s3}, (k < 3) ? 64'd1 : 64'd0);
            tick();
        end
        applyStimulus(1'b1, FPU_OP_SGNJ, FPU_FMT_S, {32'hFFFF_FFFF, 32'h4000_0003},
                      64'hFFFF_FFFF_8000_0000, 1'b1, 1'b0, 1'b0);
        checkOutput("bp_release_ready", {63'd0, rdy_s3}, 64'd1);
        checkOutput("bp_release_valid", {63'd0, vld_s3}, 64'd1);
        tick();
        for (int k = 0; k < 3; k++) begin
            applyStimulus(1'b0, FPU_OP_ADD, FPU_FMT_S, 64'd0, 64'd0, 1'b1, 1'b0, 1'b0);
            checkOutput($sformatf("bp_stream_%0d", k), {63'd0, vld_s3}, 64'd1);
            tick();
        end
        idle(5);

        // Flush a full 2-stage pipeline while a new input is offered
        for (int k = 0; k < 2; k++) begin
            applyStimulus(1'b1, FPU_OP_SGNJN, FPU_FMT_D, 64'h3FF0_0000_0000_0000 + k,
                          64'd0, 1'b0, 1'b0, 1'b0);
            tick();
        end
        checkOutput("flush_full_ready_s2", {63'd0, rdy_s2}, 64'd0);
        applyStimulus(1'b1, FPU_OP_SGNJ, FPU_FMT_D, 64'h1234_5678_9ABC_DEF0,
                      64'h8000_0000_0000_0000, 1'b0, 1'b1, 1'b0);
        tick();
        applyStimulus(1'b0, FPU_OP_ADD, FPU_FMT_S, 64'd0, 64'd0, 1'b1, 1'b0, 1'b0);
        checkOutput("flush_valid_s2", {63'd0, vld_s2}, 64'd0);
        checkOutput("flush_data_s2", out_s2, 64'd0);
        checkOutput("flush_valid_s3", {63'd0, vld_s3}, 64'd0);
        for (int k = 0; k < 4; k++) begin
            applyStimulus(1'b0, FPU_OP_ADD, FPU_FMT_S, 64'd0, 64'd0, 1'b1, 1'b0, 1'b0);
            checkOutput($sformatf("flush_quiet_%0d", k), {63'd0, vld_s2}, 64'd0);
            tick();
        end

        // Unclaimed opcode is never captured
        for (int k = 0; k < 3; k++) begin
            applyStimulus(1'b1, FPU_OP_ADD, FPU_FMT_D, 64'h4000_0000_0000_0000,
                          64'h8000_0000_0000_0000, 1'b1, 1'b0, 1'b0);
            checkOutput($sformatf("add_ready_%0d", k), {63'd0, rdy_s3}, 64'd1);
            tick();
        end
        for (int k = 0; k < 4; k++) begin
            applyStimulus(1'b0, FPU_OP_ADD, FPU_FMT_S, 64'd0, 64'd0, 1'b1, 1'b0, 1'b0);
            checkOutput($sformatf("add_quiet_%0d", k), {63'd0, vld_s3 | vld_s2 | vld_s1}, 64'd0);
            tick();
        end

        // Reset mid-operation discards in-flight results
        for (int k = 0; k < 2; k++) begin
            applyStimulus(1'b1, FPU_OP_SGNJX, FPU_FMT_S, 64'hFFFF_FFFF_C0A0_0000,
                          64'hFFFF_FFFF_8000_0000, 1'b0, 1'b0, 1'b0);
            tick();
        end
        applyStimulus(1'b1, FPU_OP_SGNJ, FPU_FMT_S, 64'd0, 64'd0, 1'b0, 1'b0, 1'b1);
        tick();
        applyStimulus(1'b0, FPU_OP_ADD, FPU_FMT_S, 64'd0, 64'd0, 1'b1, 1'b0, 1'b0);
        checkOutput("midreset_valid_s3", {63'd0, vld_s3}, 64'd0);
        checkOutput("midreset_data_s3", out_s3, 64'd0);
        checkOutput("midreset_ready_s3", {63'd0, rdy_s3}, 64'd1);
        idle(6);

        // Randomised traffic with backpressure, rare flushes and resets
        for (int n = 0; n < 600; n++) begin
            ra = {($urandom_range(0, 1) != 0) ? 32'hFFFF_FFFF : $urandom, $urandom};
            rb = {($urandom_range(0, 1) != 0) ? 32'hFFFF_FFFF : $urandom, $urandom};
            applyStimulus($urandom_range(0, 3) != 0, ops_tbl[$urandom_range(0, 4)],
                          1'($urandom_range(0, 1)), ra, rb, $urandom_range(0, 9) < 7,
                          $urandom_range(0, 49) == 0, $urandom_range(0, 99) == 0);
            tick();
        end
        idle(10);
        for (int i = 0; i < 3; i++) begin
            left = 0;
            foreach (sb[j]) if (sb[j].idx == i) left++;
            checkOutput($sformatf("drain_left%0d", i), 64'(left), 64'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
